memory_island_rsp_buf: RTL
==========================

MEMORY_ISLAND_RSP_BUF -- requirements
Module: memory_island_rsp_buf

Interface
REQ-001 SHALL have parameter AddrWidth, default 32: address width in bits.
REQ-002 SHALL have parameter DataWidth, default 64: data width in bits, a multiple of 8.
REQ-003 SHALL have parameter Depth, default 4: maximum outstanding plus buffered responses, at least 1.
REQ-004 SHALL have port clk_i  in  1  single clock, all logic on rising edge.
REQ-005 SHALL have port rst_ni  in  1  reset, asynchronous and active-low.
REQ-006 SHALL have ports us_req_i, us_addr_i, us_we_i, us_wdata_i, us_strb_i  in  1/AddrWidth/1/DataWidth/DataWidth/8  upstream request.
REQ-007 SHALL have port us_gnt_o  out  1  upstream grant.
REQ-008 SHALL have ports us_rsp_valid_o / us_rsp_rdata_o  out  1/DataWidth  upstream response; us_rsp_ready_i  in  1  response accept.
REQ-009 SHALL have ports mem_req_o, mem_addr_o, mem_we_o, mem_wdata_o, mem_strb_o  out  as REQ-006  request to memory_island_core port.
REQ-010 SHALL have ports mem_gnt_i, mem_rvalid_i  in  1; mem_rdata_i  in  DataWidth  core grant and response.
REQ-011 SHALL have ports inflight_o  out  $clog2(Depth+1)  granted-not-returned count; err_o  out  1  sticky protocol error.

Function
REQ-012 SHALL hold credit = Depth - inflight - fifo_count; never negative.
REQ-013 SHALL drive mem_req_o = us_req_i AND credit!=0; addr/we/wdata/strb pass combinationally.
REQ-014 SHALL drive us_gnt_o = mem_gnt_i AND credit!=0; a request is issued when mem_req_o AND mem_gnt_i.
REQ-015 SHALL assume core returns exactly one mem_rvalid_i per issued request (reads and writes), in order, lossless.
REQ-016 SHALL increment inflight on issue, decrement on mem_rvalid_i; both same cycle: unchanged.
REQ-017 SHALL push mem_rdata_i into a Depth-entry FIFO on mem_rvalid_i; pointers wrap modulo Depth.
REQ-018 SHALL assert us_rsp_valid_o when FIFO non-empty; pop on us_rsp_valid_o AND us_rsp_ready_i; head data on us_rsp_rdata_o.
REQ-019 SHALL allow push and pop same cycle at any fill level, including full (pop frees slot first).
REQ-020 SHALL, with credit==0, hold mem_req_o and us_gnt_o low; credit freed by a pop is usable the next cycle.
REQ-021 SHALL set err_o on mem_rvalid_i with inflight==0, or push when full with no pop; erroneous push dropped, counters saturate.
REQ-022 SHALL give minimum latency mem_rvalid_i to us_rsp_valid_o of 1 cycle (registered FIFO).

Reset
REQ-023 SHALL, on rst_ni low, asynchronously clear inflight, FIFO pointers/count and err_o.
REQ-024 SHALL drive in reset: us_gnt_o=0 only if mem_gnt_i=0 (combinational), us_rsp_valid_o=0, inflight_o=0, err_o=0, us_rsp_rdata_o=0.
REQ-025 SHALL discard in-flight requests on reset mid-operation; later mem_rvalid_i with inflight==0 sets err_o.

Configuration
REQ-026 SHALL, with MEMORY_ISLAND_RSP_BUF_FALLTHROUGH_EN defined, bypass the FIFO when empty: mem_rvalid_i AND us_rsp_ready_i presents mem_rdata_i on us_rsp_rdata_o with us_rsp_valid_o same cycle, no push.
REQ-027 SHALL, without the macro, always register through FIFO per REQ-022; credit accounting is identical in both builds.

Verification
REQ-028 SHALL cover: Depth=4, ready=1, core latency 1, 8 back-to-back reads -> 8 responses in order, data matches, inflight_o never >2.
REQ-029 SHALL cover: ready=0, 6 requests -> exactly 4 granted, us_gnt_o low thereafter; one pop -> one further grant next cycle.
REQ-030 SHALL cover: FIFO full, same-cycle pop and mem_rvalid_i -> count stays 4, no err_o, order preserved.
REQ-031 SHALL cover: mem_rvalid_i with inflight_o=0 -> err_o=1 sticky until reset.
REQ-032 SHALL cover: rst_ni low with 3 inflight -> outputs per REQ-024 immediately, inflight_o=0.
REQ-033 SHALL cover: FALLTHROUGH_EN build, empty FIFO, ready=1 -> response same cycle as mem_rvalid_i; without macro -> one cycle later.

Source files
------------

// File: rtl/memory_island_rsp_buf.sv
// memory_island_rsp_buf
// Credit-based response buffer placed in front of a memory_island_core port.
// Requests pass combinationally to the core while credit is available; each
// granted request reserves one response slot, so the response FIFO can never
// be overrun by a well-behaved core. Responses are returned upstream in order.
//
// Ports:
//   clk_i, rst_ni                     clock, asynchronous active-low reset
//   us_req_i/us_addr_i/us_we_i/
//   us_wdata_i/us_strb_i              upstream request
//   us_gnt_o                          upstream grant (combinational)
//   us_rsp_valid_o/us_rsp_rdata_o/
//   us_rsp_ready_i                    upstream response handshake
//   mem_req_o/mem_addr_o/mem_we_o/
//   mem_wdata_o/mem_strb_o            request towards the core
//   mem_gnt_i/mem_rvalid_i/mem_rdata_i core grant and response
//   inflight_o                        granted-but-not-returned count
//   err_o                             sticky protocol error
//
// Build option: define MEMORY_ISLAND_RSP_BUF_FALLTHROUGH_EN to let a response
// bypass an empty FIFO in the cycle it arrives when upstream is ready.
module memory_island_rsp_buf #(
  parameter int unsigned AddrWidth = 32,
  parameter int unsigned DataWidth = 64,
  parameter int unsigned Depth     = 4
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic                         us_req_i,
  input  logic [AddrWidth-1:0]         us_addr_i,
  input  logic                         us_we_i,
  input  logic [DataWidth-1:0]         us_wdata_i,
  input  logic [DataWidth/8-1:0]       us_strb_i,
  output logic                         us_gnt_o,
  output logic                         us_rsp_valid_o,
  output logic [DataWidth-1:0]         us_rsp_rdata_o,
  input  logic                         us_rsp_ready_i,
  output logic                         mem_req_o,
  output logic [AddrWidth-1:0]         mem_addr_o,
  output logic                         mem_we_o,
  output logic [DataWidth-1:0]         mem_wdata_o,
  output logic [DataWidth/8-1:0]       mem_strb_o,
  input  logic                         mem_gnt_i,
  input  logic                         mem_rvalid_i,
  input  logic [DataWidth-1:0]         mem_rdata_i,
  output logic [$clog2(Depth+1)-1:0]   inflight_o,
  output logic                         err_o
);

  localparam int unsigned CntW = $clog2(Depth + 1);
  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam logic [CntW:0]   DepthWide = (CntW + 1)'(Depth);
  localparam logic [CntW-1:0] DepthCnt  = CntW'(Depth);
  localparam logic [CntW-1:0] CntZero   = {CntW{1'b0}};
  localparam logic [CntW-1:0] CntOne    = CntW'(1'b1);
  localparam logic [PtrW-1:0] PtrZero   = {PtrW{1'b0}};
  localparam logic [PtrW-1:0] PtrLast   = PtrW'(Depth - 1);

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] ptr);
    if (ptr == PtrLast) begin
      return PtrZero;
    end else begin
      return ptr + PtrW'(1'b1);
    end
  endfunction

  logic [CntW-1:0]      inflight_r, inflight_d;
  logic [CntW-1:0]      count_r, count_d;
  logic [PtrW-1:0]      wptr_r, wptr_d;
  logic [PtrW-1:0]      rptr_r, rptr_d;
  logic                 err_r, err_d;
  logic [DataWidth-1:0] store_r [Depth];

  logic [CntW:0] used_s;
  logic          credit_s;
  logic          issue_s;
  logic          rsp_legal_s;
  logic          fifo_empty_s;
  logic          fifo_full_s;
  logic          bypass_s;
  logic          pop_s;
  logic          push_req_s;
  logic          overflow_s;
  logic          push_s;
  logic          err_set_s;

  // Slots already spoken for: responses still at the core plus those buffered.
  assign used_s   = {1'b0, inflight_r} + {1'b0, count_r};
  assign credit_s = (used_s < DepthWide);

  assign mem_req_o   = us_req_i & credit_s;
  assign us_gnt_o    = mem_gnt_i & credit_s;
  assign mem_addr_o  = us_addr_i;
  assign mem_we_o    = us_we_i;
  assign mem_wdata_o = us_wdata_i;
  assign mem_strb_o  = us_strb_i;
  assign issue_s     = mem_req_o & mem_gnt_i;

  // A response with nothing outstanding has no owner; it is flagged and dropped.
  assign rsp_legal_s  = mem_rvalid_i & (inflight_r != CntZero);
  assign fifo_empty_s = (count_r == CntZero);
  assign fifo_full_s  = (count_r == DepthCnt);

`ifdef MEMORY_ISLAND_RSP_BUF_FALLTHROUGH_EN
  // Gated with rst_ni so nothing is presented upstream while in reset.
  assign bypass_s = rsp_legal_s & fifo_empty_s & us_rsp_ready_i & rst_ni;
`else
  assign bypass_s = 1'b0;
`endif

  assign us_rsp_valid_o = ~fifo_empty_s | bypass_s;
  assign us_rsp_rdata_o = (~fifo_empty_s) ? store_r[rptr_r] :
                          (bypass_s ? mem_rdata_i : {DataWidth{1'b0}});

  // Pop is evaluated before push so a full FIFO can accept and release together.
  assign pop_s      = ~fifo_empty_s & us_rsp_ready_i;
  assign push_req_s = rsp_legal_s & ~bypass_s;
  assign overflow_s = push_req_s & fifo_full_s & ~pop_s;
  assign push_s     = push_req_s & ~overflow_s;
  assign err_set_s  = (mem_rvalid_i & (inflight_r == CntZero)) | overflow_s;

  // Next-state for the outstanding counter, FIFO bookkeeping and sticky error.
  always_comb begin
    inflight_d = inflight_r;
    count_d    = count_r;
    wptr_d     = wptr_r;
    rptr_d     = rptr_r;
    err_d      = err_r | err_set_s;

    case ({issue_s, rsp_legal_s})
      2'b10:   inflight_d = inflight_r + CntOne;
      2'b01:   inflight_d = inflight_r - CntOne;
      default: inflight_d = inflight_r;
    endcase

    case ({push_s, pop_s})
      2'b10:   count_d = count_r + CntOne;
      2'b01:   count_d = count_r - CntOne;
      default: count_d = count_r;
    endcase

    if (push_s) begin
      wptr_d = ptr_inc(wptr_r);
    end else begin
      wptr_d = wptr_r;
    end

    if (pop_s) begin
      rptr_d = ptr_inc(rptr_r);
    end else begin
      rptr_d = rptr_r;
    end
  end

  // Control state register with asynchronous clear.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      inflight_r <= CntZero;
      count_r    <= CntZero;
      wptr_r     <= PtrZero;
      rptr_r     <= PtrZero;
      err_r      <= 1'b0;
    end else begin
      inflight_r <= inflight_d;
      count_r    <= count_d;
      wptr_r     <= wptr_d;
      rptr_r     <= rptr_d;
      err_r      <= err_d;
    end
  end

  // Response storage; contents are only observed through a valid head slot.
  always_ff @(posedge clk_i) begin
    if (push_s) begin
      store_r[wptr_r] <= mem_rdata_i;
    end
  end

  assign inflight_o = inflight_r;
  assign err_o      = err_r;

endmodule
